// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES slices,
// one registered full-adder chain per slice, valid/ready handshake with global stall.
module pipelined_rca_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SliceW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] op_a    [STAGES];
  logic [WIDTH-1:0] op_b    [STAGES];
  logic [WIDTH-1:0] sum_in  [STAGES];
  logic [WIDTH-1:0] sum_out [STAGES];
  logic             c_in    [STAGES];
  logic             c_out   [STAGES];
  logic             vld_in  [STAGES];
  logic             vld_out [STAGES];

  // Whole pipeline advances together; bubbles are not squeezed out.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign op_a[0]   = a;
  assign op_b[0]   = sub ? ~b : b;
  assign c_in[0]   = sub | cin;
  assign sum_in[0] = '0;
  assign vld_in[0] = in_valid;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign c_in[k]   = c_out[k-1];
    assign sum_in[k] = sum_out[k-1];
    assign vld_in[k] = vld_out[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SliceW-1:0] x;
    logic [SliceW-1:0] y;
    logic [SliceW-1:0] sl_sum;
    logic              carry;
    logic [WIDTH-1:0]  sum_d;
    logic              vld_q;
    logic              c_q;
    logic [WIDTH-1:0]  sum_q;

    assign x = op_a[k][k*SliceW +: SliceW];
    assign y = op_b[k][k*SliceW +: SliceW];

    always_comb begin
      sl_sum = '0;
      carry  = c_in[k];
      for (int i = 0; i < SliceW; i++) begin
        sl_sum[i] = x[i] ^ y[i] ^ carry;
        carry     = (x[i] & y[i]) | (x[i] & carry) | (y[i] & carry);
      end
    end

    // Earlier slices arrive already placed; this stage ORs its own slice in.
    always_comb begin
      sum_d                      = '0;
      sum_d[k*SliceW +: SliceW]  = sl_sum;
      sum_d                      = sum_d | sum_in[k];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_in[k];
        c_q   <= carry;
        sum_q <= sum_d;
      end
    end

    assign vld_out[k] = vld_q;
    assign c_out[k]   = c_q;
    assign sum_out[k] = sum_q;

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= op_a[k];
          b_q <= op_b[k];
        end
      end

      assign op_a[k+1] = a_q;
      assign op_b[k+1] = b_q;
    end else begin : g_last
      logic ovf_q;
      logic unused_ops;

      // Carry into the MSB is recovered as sum ^ x ^ y of the top bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= x[SliceW-1] ^ y[SliceW-1] ^ sl_sum[SliceW-1] ^ carry;
        end
      end

      assign ovf        = ovf_q;
      assign unused_ops = ^{op_a[k], op_b[k]};
    end
  end

  assign out_valid = vld_out[STAGES-1];
  assign s         = sum_out[STAGES-1];
  assign cout      = c_out[STAGES-1];

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed bench for pipelined_rca_adder at STAGES = 4, 1 and 16 sharing one stimulus;
// per-instance expected queues track order, values and latency.
module tb_pipelined_rca_adder;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic [31:0]  acc;
    logic         lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         iv4, iv1, iv16, rdy4, rdy1, rdy16;
  logic         ir4, ir1, ir16, ov4, ov1, ov16;
  logic         co4, co1, co16, of4, of1, of16;
  logic [W-1:0] s4, s1, s16;
  logic [W-1:0] es;
  logic         ec, eo, lat_on;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;
  exp_t         q4[$], q1[$], q16[$];
  exp_t         m4, m1, m16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_rca_adder #(.WIDTH(W), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov4), .out_ready(rdy4), .s(s4), .cout(co4), .ovf(of4)
  );
  pipelined_rca_adder #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(rdy1), .s(s1), .cout(co1), .ovf(of1)
  );
  pipelined_rca_adder #(.WIDTH(W), .STAGES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov16), .out_ready(rdy16), .s(s16), .cout(co16), .ovf(of16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_beat(input string tag, input exp_t e, input logic [W-1:0] gs,
                            input logic gc, input logic go, input int stages);
    check({tag, "_s"}, 32'(gs), 32'(e.s));
    check({tag, "_cout"}, 32'(gc), 32'(e.c));
    check({tag, "_ovf"}, 32'(go), 32'(e.o));
    if (e.lat) check({tag, "_lat"}, 32'(cyc) - e.acc, 32'(stages));
  endtask

  // Pop before push so a spurious out_valid on an empty queue is never masked.
  always @(negedge clk) begin
    if (!rst) begin
      if (q4.size() == 0) check("idle4", 32'(ov4), 32'd0);
      else if (ov4 && rdy4) begin
        m4 = q4.pop_front();
        check_beat("d4", m4, s4, co4, of4, 4);
      end
      if (iv4 && ir4) begin
        m4.s = es; m4.c = ec; m4.o = eo; m4.acc = 32'(cyc); m4.lat = lat_on;
        q4.push_back(m4);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ov1 && rdy1) begin
        if (q1.size() == 0) check("extra1", 32'(ov1), 32'd0);
        else begin
          m1 = q1.pop_front();
          check_beat("d1", m1, s1, co1, of1, 1);
        end
      end
      if (iv1 && ir1) begin
        m1.s = es; m1.c = ec; m1.o = eo; m1.acc = 32'(cyc); m1.lat = lat_on;
        q1.push_back(m1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ov16 && rdy16) begin
        if (q16.size() == 0) check("extra16", 32'(ov16), 32'd0);
        else begin
          m16 = q16.pop_front();
          check_beat("d16", m16, s16, co16, of16, 16);
        end
      end
      if (iv16 && ir16) begin
        m16.s = es; m16.c = ec; m16.o = eo; m16.acc = 32'(cyc); m16.lat = lat_on;
        q16.push_back(m16);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                      input logic tsub, input logic [W-1:0] ts, input logic tc, input logic to,
                      input logic all);
    int n = 0;
    a = ta; b = tb; cin = tcin; sub = tsub;
    es = ts; ec = tc; eo = to;
    iv4 = 1'b1; iv1 = all; iv16 = all;
    do begin
      @(negedge clk);
      n++;
    end while (!ir4 && n < 50);
    if (!ir4) check("send_ready", 32'(ir4), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iv4 = 1'b0; iv1 = 1'b0; iv16 = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q4.size() + q1.size() + q16.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q4.size() + q1.size() + q16.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov4(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov4 && n < 50);
    check(tag, 32'(ov4), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle();
    rdy4 = 1'b1; rdy1 = 1'b1; rdy16 = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    es = '0; ec = 1'b0; eo = 1'b0; lat_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ov4", 32'(ov4), 32'd0);
    check("rst_ov1", 32'(ov1), 32'd0);
    check("rst_ov16", 32'(ov16), 32'd0);
    check("rst_s4", 32'(s4), 32'd0);
    check("rst_cout4", 32'(co4), 32'd0);
    check("rst_ovf4", 32'(of4), 32'd0);
    check("rst_ir4", 32'(ir4), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single add, then carry/overflow edges and carry-in
    send(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1);
    idle();
    wait_drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(16'h0009, 16'h000D, 1'b1, 1'b0, 16'h0017, 1'b0, 1'b0, 1'b1);
    // Subtract; cin must have no effect
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    send(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    idle();
    wait_drain();

    // Back-to-back stream of 8 beats
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
    send(16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    send(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    send(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'hC000, 16'h4000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
    idle();
    wait_drain();

    // Backpressure: beat 2 (0x0202) must sit on the output for 5 stalled cycles
    lat_on = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(16'(i << 8), 16'(i), 1'b0, 1'b0, 16'((i << 8) | i), 1'b0, 1'b0, 1'b0);
        idle();
      end
      begin
        wait_ov4("stall_ov");
        @(posedge clk);
        #1 rdy4 = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check("stall_ir", 32'(ir4), 32'd0);
          check("stall_ov_hold", 32'(ov4), 32'd1);
          check("stall_s", 32'(s4), 32'h0202);
        end
        @(posedge clk);
        #1 rdy4 = 1'b1;
      end
    join
    wait_drain();
    lat_on = 1'b1;

    // Reset with beats in flight, then a fresh beat
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    send(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0);
    send(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);
    idle();
    wait_ov4("inflight_ov");
    rst = 1'b1;
    #1;
    check("rst_mid_ov", 32'(ov4), 32'd0);
    check("rst_mid_s", 32'(s4), 32'd0);
    q4.delete(); q1.delete(); q16.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    idle();
    wait_drain();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
